// File: rtl/nanorv32_code_ahb_slave.sv
// Read-only AHB-Lite slave in front of a synchronous code SRAM.
// Good word reads stream at one per cycle when WAIT_STATES=0; everything else gets a two-cycle ERROR.
module nanorv32_code_ahb_slave #(
    parameter int          MEM_AWIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic                  mem_en,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            err_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    localparam logic [32:0] WIN_BYTES = 33'd1 << (MEM_AWIDTH + 2);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    logic [2:0]  state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [32:0] offset;
    logic        addr_phase, active, accept, good;

    // Only states that drive hreadyout=1 can host an address phase, so a
    // stray hready during our own stall can never start a new transfer.
    assign addr_phase = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign active     = (htrans == 2'b10) || (htrans == 2'b11);
    assign accept     = rst_n & addr_phase & hsel & active & hready;

    // 33-bit difference: an address below the base wraps to bit 32 set and
    // therefore also fails the single upper-bound compare.
    assign offset   = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign good     = !hwrite && (hsize == 3'b010) && (haddr[1:0] == 2'b00) && (offset < WIN_BYTES);
    assign mem_en   = accept & good;
    assign mem_addr = offset[MEM_AWIDTH+1:2];

    assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign hrdata    = (state == S_DATA) ? mem_rdata : 32'h0;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_WAIT: begin
                wait_cnt_nxt = (wait_cnt == 4'd0) ? 4'd0 : wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1)
                    state_nxt = S_DATA;
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (!good) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_INIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            err_count <= 8'h00;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept && !good && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_nanorv32_code_ahb_slave.sv
// Bench for the code AHB slave: three instances (0, 2 and 3 wait states) share one
// stimulus stream, each with its own hready loop, and are compared to a transaction model.
module tb_nanorv32_code_ahb_slave;

    localparam int          AW    = 6;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0200;
    localparam longint      BASEL = 64'h200;

    logic        clk, rst_n;
    logic        hsel, hwrite;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    logic          hro  [3];
    logic          hrsp [3];
    logic          men  [3];
    logic [31:0]   hrd  [3];
    logic [31:0]   mrd  [3];
    logic [AW-1:0] maddr[3];
    logic [7:0]    errc [3];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] memword(int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0103);
    endfunction

    nanorv32_code_ahb_slave #(.MEM_AWIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hready(hro[0]), .hreadyout(hro[0]), .hresp(hrsp[0]), .hrdata(hrd[0]),
        .mem_en(men[0]), .mem_addr(maddr[0]), .mem_rdata(mrd[0]), .err_count(errc[0]));

    nanorv32_code_ahb_slave #(.MEM_AWIDTH(AW), .WAIT_STATES(2), .BASE_ADDR(BASE)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hready(hro[1]), .hreadyout(hro[1]), .hresp(hrsp[1]), .hrdata(hrd[1]),
        .mem_en(men[1]), .mem_addr(maddr[1]), .mem_rdata(mrd[1]), .err_count(errc[1]));

    nanorv32_code_ahb_slave #(.MEM_AWIDTH(AW), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hready(hro[2]), .hreadyout(hro[2]), .hresp(hrsp[2]), .hrdata(hrd[2]),
        .mem_en(men[2]), .mem_addr(maddr[2]), .mem_rdata(mrd[2]), .err_count(errc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data appears the cycle after mem_en and holds until the next one.
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (men[k]) mrd[k] <= memword(int'(maddr[k]));

    // Transaction model: the last accepted transfer and the cycle it was accepted in.
    int     ws[3] = '{0, 2, 3};
    int     pkind[3];
    longint pt[3];
    int     pidx[3];
    int     merr[3];
    longint cyc = 0;

    function automatic void model_out(int k, output logic rdy, output logic rsp, output logic [31:0] dat);
        longint d = cyc - pt[k];
        rdy = 1'b1; rsp = 1'b0; dat = 32'h0;
        if (pkind[k] == 1) begin
            if (d >= 1 && d <= ws[k]) rdy = 1'b0;
            else if (d == ws[k] + 1) dat = memword(pidx[k]);
        end else if (pkind[k] == 2) begin
            if (d == 1) begin rdy = 1'b0; rsp = 1'b1; end
            else if (d == 2) rsp = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin pkind[k] = 0; pt[k] = 0; pidx[k] = 0; merr[k] = 0; end
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", name, k, act, exp);
        end
    endtask

    // One bus cycle: compare every instance against the model at the falling edge,
    // advance the model, then return just after the next rising edge.
    task automatic cycle();
        logic rdy, rsp, acc, good;
        logic [31:0] dat;
        longint a;
        @(negedge clk);
        a    = longint'({32'd0, haddr});
        good = !hwrite && (hsize == 3'b010) && (haddr[1:0] == 2'b00) && (a >= BASEL) && (a < BASEL + 4 * DEPTH);
        for (int k = 0; k < 3; k++) begin
            model_out(k, rdy, rsp, dat);
            check("hreadyout", k, hro[k], rdy);
            check("hresp", k, hrsp[k], rsp);
            check("hrdata", k, hrd[k], dat);
            check("err_count", k, errc[k], merr[k]);
            acc = hsel && htrans[1] && rdy;
            check("mem_en", k, men[k], acc && good);
            if (acc && good) check("mem_addr", k, maddr[k], 32'((a - BASEL) / 4));
            if (acc) begin
                pkind[k] = good ? 1 : 2;
                pt[k]    = cyc;
                if (good) pidx[k] = int'((a - BASEL) / 4);
                else if (merr[k] < 255) merr[k]++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h0;
    endtask

    task automatic rd(logic [31:0] a);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = a;
    endtask

    task automatic rand_inputs();
        logic [31:0] off;
        int r;
        hsel   = ($urandom_range(0, 3) != 0);
        htrans = 2'($urandom_range(0, 3));
        hwrite = ($urandom_range(0, 7) == 0);
        hsize  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
        r      = int'($urandom_range(0, 9));
        off    = 32'($urandom_range(0, (4 * DEPTH + 32) / 4)) * 32'd4;
        if (r == 1) off = off + 32'($urandom_range(1, 3));
        haddr  = (r == 0) ? $urandom : BASE - 32'd16 + off;
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic        exp_en;
        logic        exp_rdy;
        logic        exp_rsp;
    } vec_t;

    vec_t vt[13];

    initial begin
        // Isolated transfers on the zero-wait instance: address-phase mem_en,
        // then hreadyout/hresp in the following cycle.
        vt[0]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0200, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_02FC, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0300, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_01FC, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 2'b10, 1'b1, 3'b010, 32'h0000_0200, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0202, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'b10, 1'b0, 3'b001, 32'h0000_0204, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 2'b10, 1'b0, 3'b010, 32'h0000_0208, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 2'b00, 1'b0, 3'b010, 32'h0000_0208, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0208, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b1, 2'b11, 1'b0, 3'b010, 32'h0000_0210, 1'b1, 1'b1, 1'b0};
        vt[11] = '{1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b1, 2'b10, 1'b0, 3'b010, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};

        model_reset();
        rst_n = 1'b0;
        idle();
        #2;
        for (int k = 0; k < 3; k++) begin
            check("rst_hreadyout", k, hro[k], 1);
            check("rst_hresp", k, hrsp[k], 0);
            check("rst_hrdata", k, hrd[k], 0);
            check("rst_mem_en", k, men[k], 0);
            check("rst_err_count", k, errc[k], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cycle();

        for (int i = 0; i < 13; i++) begin
            hsel = vt[i].sel; htrans = vt[i].trans; hwrite = vt[i].wr;
            hsize = vt[i].size; haddr = vt[i].addr;
            #1;
            check("tbl_mem_en", i, men[0], vt[i].exp_en);
            cycle();
            idle();
            #1;
            check("tbl_hreadyout", i, hro[0], vt[i].exp_rdy);
            check("tbl_hresp", i, hrsp[0], vt[i].exp_rsp);
            repeat (4) cycle();
        end

        // Back-to-back zero-wait reads: one word per cycle.
        for (int j = 0; j < 3; j++) begin
            rd(BASE + 32'(4 * j));
            #1;
            check("b2b_mem_en", j, men[0], 1);
            check("b2b_mem_addr", j, maddr[0], 32'(j));
            if (j > 0) begin
                check("b2b_hrdata", j, hrd[0], memword(j - 1));
                check("b2b_hreadyout", j, hro[0], 1);
            end
            cycle();
        end
        idle();
        #1;
        check("b2b_hrdata", 3, hrd[0], memword(2));
        check("b2b_hreadyout", 3, hro[0], 1);
        repeat (5) cycle();

        // Two wait states on the second instance: 0,0,1 then data.
        rd(BASE + 32'h10);
        cycle();
        idle();
        for (int t = 0; t < 3; t++) begin
            #1;
            check("ws2_hreadyout", t, hro[1], (t == 2) ? 1 : 0);
            check("ws2_hresp", t, hrsp[1], 0);
            if (t == 2) check("ws2_hrdata", t, hrd[1], memword(4));
            cycle();
        end
        repeat (3) cycle();

        // Reset pulse while the three-wait instance is stalled.
        rd(BASE);
        cycle();
        idle();
        cycle();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("midrst_hreadyout", k, hro[k], 1);
            check("midrst_hresp", k, hrsp[k], 0);
            check("midrst_hrdata", k, hrd[k], 0);
            check("midrst_mem_en", k, men[k], 0);
            check("midrst_err_count", k, errc[k], 0);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(BASE + 32'hC);
        cycle();
        idle();
        repeat (3) cycle();
        #1;
        check("postrst_hreadyout", 2, hro[2], 1);
        check("postrst_hrdata", 2, hrd[2], memword(3));
        repeat (3) cycle();

        // Write then misaligned read: two ERROR responses each, never a mem_en.
        for (int e = 0; e < 2; e++) begin
            if (e == 0) begin rd(BASE); hwrite = 1'b1; end
            else rd(BASE + 32'h2);
            #1;
            check("err_mem_en", e, men[0], 0);
            cycle();
            idle();
            #1;
            check("err1_hreadyout", e, hro[0], 0);
            check("err1_hresp", e, hrsp[0], 1);
            cycle();
            #1;
            check("err2_hreadyout", e, hro[0], 1);
            check("err2_hresp", e, hrsp[0], 1);
            cycle();
        end
        check("err_count_two", 0, errc[0], 2);
        repeat (3) cycle();

        repeat (400) begin
            rand_inputs();
            cycle();
        end
        idle();
        repeat (5) cycle();

        // Continuous writes until every counter saturates.
        rd(BASE);
        hwrite = 1'b1;
        repeat (600) cycle();
        for (int k = 0; k < 3; k++) check("err_sat", k, errc[k], 8'hFF);
        repeat (10) cycle();
        idle();
        repeat (4) cycle();
        for (int k = 0; k < 3; k++) check("err_hold", k, errc[k], 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
